// File: rtl/rc_osc_freq_counter.sv
// Multi-channel RC-oscillator frequency counter: counts synchronised rising
// edges of each osc_in bit over a programmable gate window and latches the result set.
module rc_osc_freq_counter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH-1:0]                             osc_in,
  input  logic [NUM_CH-1:0]                             ch_en,
  input  logic [GATE_W-1:0]                             gate_len,
  input  logic                                          start,
  input  logic                                          cont,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
  output logic [CNT_W-1:0]                              rd_count,
  output logic                                          rd_ovf,
  output logic                                          res_valid,
  input  logic                                          res_ack,
  output logic                                          overrun,
  output logic                                          busy,
  output logic                                          done,
  output logic [1:0]                                    fsm_state
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_GATE  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [1:0]        state;
  logic [NUM_CH-1:0] sync1, sync2, sync3;
  logic [NUM_CH-1:0] edge_pulse;
  logic [NUM_CH-1:0] en_q;
  logic [GATE_W-1:0] len_q;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  live_cnt [NUM_CH];
  logic [NUM_CH-1:0] live_ovf;
  logic [CNT_W-1:0]  res_cnt [NUM_CH];
  logic [NUM_CH-1:0] res_ovf;

  // Two flops resolve metastability; the third gives the previous level for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_pulse = sync2 & ~sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      en_q     <= '0;
      len_q    <= '0;
      gate_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start || cont) state <= S_ARM;
        end
        S_ARM: begin
          en_q     <= ch_en;
          len_q    <= (gate_len == '0) ? GATE_W'(1) : gate_len;
          gate_cnt <= '0;
          state    <= S_GATE;
        end
        S_GATE: begin
          gate_cnt <= gate_cnt + GATE_W'(1);
          if (gate_cnt == len_q - GATE_W'(1)) state <= S_LATCH;
        end
        S_LATCH: begin
          state <= cont ? S_ARM : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Counters stick at full scale; a further edge only raises the overflow flag.
  always_ff @(posedge clk) begin
    if (rst || state == S_ARM) begin
      for (int i = 0; i < NUM_CH; i++) live_cnt[i] <= '0;
      live_ovf <= '0;
    end else if (state == S_GATE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (en_q[i] && edge_pulse[i]) begin
          if (live_cnt[i] == CNT_MAX) live_ovf[i] <= 1'b1;
          else                        live_cnt[i] <= live_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) res_cnt[i] <= '0;
      res_ovf <= '0;
    end else if (state == S_LATCH) begin
      for (int i = 0; i < NUM_CH; i++) res_cnt[i] <= live_cnt[i];
      res_ovf <= live_ovf;
    end
  end

  // res_valid/res_ack: res_valid rises in LATCH and holds until a cycle with
  // res_ack=1 outside LATCH; an ack landing in LATCH is superseded by the new set.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (state == S_LATCH) begin
      res_valid <= 1'b1;
      if (res_valid && !res_ack) overrun <= 1'b1;
    end else if (res_ack) begin
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

  always_comb begin
    rd_count = '0;
    rd_ovf   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_count = res_cnt[i];
        rd_ovf   = res_ovf[i];
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_LATCH);
  assign fsm_state = state;

endmodule

// File: tb/tb_rc_osc_freq_counter.sv
// Bench for rc_osc_freq_counter: synthetic oscillators, an edge-history reference
// model, directed windows, continuous mode, mid-window reset and random windows.
module tb_rc_osc_freq_counter;

  localparam int NCH  = 3;
  localparam int CW   = 6;
  localparam int GW   = 8;
  localparam int SW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int MAXC = 16384;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  osc_in;
  logic [NCH-1:0]  ch_en;
  logic [GW-1:0]   gate_len;
  logic            start, cont, res_ack;
  logic [SW-1:0]   rd_sel;
  logic [CW-1:0]   rd_count;
  logic            rd_ovf, res_valid, overrun, busy, done;
  logic [1:0]      fsm_state;

  int              cyc = 0;
  logic [NCH-1:0]  samp [MAXC];
  int              per [NCH];
  int              hi  [NCH];
  int              ph  [NCH];
  int              errors = 0;
  int              checks = 0;

  rc_osc_freq_counter #(.NUM_CH(NCH), .CNT_W(CW), .GATE_W(GW)) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .ch_en(ch_en), .gate_len(gate_len),
    .start(start), .cont(cont), .rd_sel(rd_sel), .rd_count(rd_count),
    .rd_ovf(rd_ovf), .res_valid(res_valid), .res_ack(res_ack),
    .overrun(overrun), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset-aware history ----------------
  always #5 clk = ~clk;

  // History of the oscillator levels seen at each rising edge; a reset edge
  // leaves the synchroniser holding zeros, so it is recorded as zero.
  always @(posedge clk) begin
    if (cyc < MAXC) samp[cyc] <= rst ? '0 : osc_in;
    cyc <= cyc + 1;
  end

  initial begin
    for (int c = 0; c < NCH; c++) begin per[c] = 0; hi[c] = 0; ph[c] = 0; end
    osc_in = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++)
        osc_in[c] = (per[c] == 0) ? 1'b0 : (((cyc + ph[c]) % per[c]) < hi[c]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: a rising edge counts in gate cycle n when the level two edges
  // earlier was high and three edges earlier was low.
  function automatic int model_edges(input int c, input int g0, input int len);
    int n_edges = 0;
    for (int n = g0; n < g0 + len; n++)
      if (samp[n-2][c] === 1'b1 && samp[n-3][c] === 1'b0) n_edges++;
    return n_edges;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_osc(input int c, input int p, input int h, input int f);
    per[c] = p; hi[c] = h; ph[c] = f;
  endtask

  task automatic verify_results(input string tag, input int g0, input int len, input logic [NCH-1:0] en);
    int e;
    logic [CW-1:0] ec;
    logic eo;
    check({tag, "_valid"}, res_valid, 1);
    for (int c = 0; c < NCH; c++) begin
      e  = model_edges(c, g0, len);
      ec = en[c] ? ((e > CMAX) ? CW'(CMAX) : CW'(e)) : '0;
      eo = en[c] && (e > CMAX);
      rd_sel = SW'(c); #1;
      check($sformatf("%s_cnt%0d", tag, c), rd_count, ec);
      check($sformatf("%s_ovf%0d", tag, c), rd_ovf, eo);
    end
    rd_sel = SW'(NCH); #1;
    check({tag, "_oob_cnt"}, rd_count, 0);
    check({tag, "_oob_ovf"}, rd_ovf, 0);
  endtask

  task automatic ack_and_check(input string tag);
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
    check({tag, "_ack_valid"}, res_valid, 0);
    check({tag, "_ack_ovr"}, overrun, 0);
  endtask

  // Caller is just after a rising edge with the block idle.
  task automatic run_window(input int len_in, input logic [NCH-1:0] en, input string tag,
                            input bit scramble, input bit do_ack);
    int p0, len, busy_n, done_n, done_k, chg;
    logic [1:0] prev;
    len = (len_in == 0) ? 1 : len_in;
    busy_n = 0; done_n = 0; done_k = -1; chg = 0;
    gate_len = GW'(len_in);
    ch_en    = en;
    start    = 1'b1;
    p0       = cyc;
    prev     = fsm_state;
    for (int k = 0; k < len + 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) start = 1'b0;
      if (fsm_state !== prev) chg++;
      prev = fsm_state;
      if (busy) busy_n++;
      if (done) begin done_n++; done_k = k; end
      if (scramble && k >= 1) begin
        gate_len = GW'($urandom);
        ch_en    = NCH'($urandom);
      end
    end
    check({tag, "_busy_cycles"}, busy_n, len + 2);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_done_pos"}, done_k, len + 1);
    check({tag, "_state_steps"}, chg, 4);
    verify_results(tag, p0 + 2, len, en);
    if (do_ack) ack_and_check(tag);
  endtask

  // ---------------- scoreboard-driven sequence ----------------
  initial begin
    int p0, done_n, cnt, wl;
    int done_q[$];
    rst = 1'b1; start = 1'b0; cont = 1'b0; res_ack = 1'b0;
    gate_len = '0; ch_en = '0; rd_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", res_valid, 0);
    check("rst_ovr", overrun, 0);
    for (int c = 0; c <= NCH; c++) begin
      rd_sel = SW'(c); #1;
      check($sformatf("rst_cnt%0d", c), rd_count, 0);
      check($sformatf("rst_ovf%0d", c), rd_ovf, 0);
    end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Single window, 8-cycle oscillator on channel 0
    set_osc(0, 8, 4, 0); set_osc(1, 0, 0, 0); set_osc(2, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    run_window(64, 3'b111, "basic", 1'b0, 1'b1);
    rd_sel = 2'd0; #1;
    check("basic_range", (rd_count >= 7 && rd_count <= 9), 1);

    // Saturation: 2-cycle oscillator over a long window
    set_osc(0, 0, 0, 0); set_osc(1, 2, 1, 0); set_osc(2, 5, 2, 1);
    repeat (4) @(posedge clk);
    #1;
    run_window(200, 3'b111, "sat", 1'b0, 1'b1);

    // Channel enable mask, left unacknowledged for the reset test
    set_osc(0, 4, 2, 0); set_osc(1, 4, 2, 1); set_osc(2, 4, 2, 3);
    repeat (4) @(posedge clk);
    #1;
    run_window(40, 3'b101, "chen", 1'b0, 1'b0);

    // Reset during the gate window: no LATCH, everything cleared
    gate_len = 8'd32; ch_en = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", res_valid, 0);
    for (int c = 0; c < NCH; c++) begin
      rd_sel = SW'(c); #1;
      check($sformatf("abort_cnt%0d", c), rd_count, 0);
    end
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_n++;
    end
    check("abort_quiet", done_n, 0);

    // Zero gate length behaves as one gate cycle
    run_window(0, 3'b111, "len0", 1'b0, 1'b1);

    // Continuous mode with late and coincident acknowledges
    set_osc(0, 3, 1, 0); set_osc(1, 6, 3, 2); set_osc(2, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    gate_len = 8'd16; ch_en = '1; cont = 1'b1; p0 = cyc;
    for (int k = 0; k <= 92; k++) begin
      @(posedge clk); #1;
      if (done) done_q.push_back(k);
      if (k == 18) check("cont_valid1", res_valid, 1);
      if (k == 35) check("cont_ovr_pre", overrun, 0);
      if (k == 36) check("cont_ovr_set", overrun, 1);
      if (k == 40) res_ack = 1'b1;
      if (k == 41) begin
        res_ack = 1'b0;
        check("cont_ack_valid", res_valid, 0);
        check("cont_ack_ovr", overrun, 0);
      end
      if (k == 54) check("cont_relatch", res_valid, 1);
      if (k == 71) res_ack = 1'b1;
      if (k == 72) begin
        res_ack = 1'b0;
        cont    = 1'b0;
        check("cont_latch_ack_ovr", overrun, 0);
        verify_results("cont", p0 + 56, 16, 3'b111);
      end
      if (k == 90) check("cont_ovr_last", overrun, 1);
    end
    check("cont_stop_busy", busy, 0);
    check("cont_done_count", done_q.size(), 5);
    for (int i = 0; i < done_q.size() && i < 5; i++)
      check($sformatf("cont_done_at%0d", i), done_q[i], 17 + 18 * i);
    ack_and_check("cont_end");

    // Random windows with mid-window changes on gate_len/ch_en
    for (int t = 0; t < 10; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 4) == 0) set_osc(c, 0, 0, 0);
        else begin
          cnt = $urandom_range(2, 14);
          set_osc(c, cnt, $urandom_range(1, cnt - 1), $urandom_range(0, cnt - 1));
        end
      end
      wl = $urandom_range(0, 200);
      repeat (4) @(posedge clk);
      #1;
      run_window(wl, NCH'($urandom), $sformatf("rnd%0d", t), 1'b1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rc_osc_freq_counter.md
RC_OSC_FREQ_COUNTER -- requirements
Module: rc_osc_freq_counter

Interface
REQ-001 Parameter NUM_CH, default 4: number of oscillator channels (1..8).
REQ-002 Parameter CNT_W, default 16: per-channel edge-count width (4..24).
REQ-003 Parameter GATE_W, default 16: gate-length field width (4..24).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 osc_in  input  NUM_CH  asynchronous RC-oscillator square waves, one bit per channel.
REQ-007 ch_en  input  NUM_CH  per-channel count enable, sampled in ARM.
REQ-008 gate_len  input  GATE_W  gate window length in clk cycles, sampled in ARM.
REQ-009 start  input  1  single-shot measurement request, level-sampled in IDLE.
REQ-010 cont  input  1  continuous mode: re-arm automatically after each window.
REQ-011 rd_sel  input  clog2(NUM_CH) (min 1)  result readout channel select.
REQ-012 rd_count  output  CNT_W  latched count of channel rd_sel (combinational mux of result registers).
REQ-013 rd_ovf  output  1  latched saturation flag of channel rd_sel.
REQ-014 res_valid  output  1  result set available, held until res_ack.
REQ-015 res_ack  input  1  consumer acknowledge; clears res_valid.
REQ-016 overrun  output  1  sticky: results replaced while res_valid was 1.
REQ-017 busy  output  1  high in ARM, GATE, LATCH.
REQ-018 done  output  1  one-cycle pulse in LATCH.

Function
REQ-019 Each osc_in bit SHALL pass a 2-flop synchroniser plus a third flop; edge pulse = sync2 & ~sync3 (rising edges only, 3-cycle latency).
REQ-020 FSM states SHALL be IDLE, ARM, GATE, LATCH; encoding free.
REQ-021 IDLE -> ARM when start=1 or cont=1; else stay.
REQ-022 ARM (1 cycle): clear all live counters and ovf bits; capture ch_en and gate_len (0 captured as 1); clear gate counter.
REQ-023 GATE: gate counter increments each cycle; GATE -> LATCH on the cycle gate counter equals captured length-1, giving exactly captured-length GATE cycles.
REQ-024 Edge pulses SHALL be counted only in GATE cycles and only for channels captured enabled; disabled channels latch count 0, ovf 0.
REQ-025 Live counter SHALL saturate at 2^CNT_W-1; an edge arriving at saturation sets that channel's live ovf bit; no wrap-around.
REQ-026 LATCH (1 cycle): copy all live counts/ovf to result registers, pulse done, set res_valid; if res_valid was already 1 and res_ack=0 in this cycle, set overrun.
REQ-027 LATCH -> ARM if cont=1, else -> IDLE; start ignored outside IDLE.
REQ-028 res_ack=1 SHALL clear res_valid and overrun next cycle, except res_ack in LATCH cycle: res_valid stays 1 (new data), overrun unchanged.
REQ-029 Result registers SHALL hold value between LATCH cycles, independent of rd_sel, res_ack, or input changes.
REQ-030 rd_sel >= NUM_CH SHALL read rd_count=0, rd_ovf=0.
REQ-031 Changes on gate_len/ch_en outside ARM SHALL not affect the window in progress.

Reset
REQ-032 rst=1 at any clock edge SHALL force IDLE and clear synchronisers, live and result counts, ovf, gate counter, res_valid, overrun, busy, done to 0; rst mid-GATE aborts with no LATCH and no done.
REQ-033 rst SHALL dominate start, cont, res_ack in the same cycle.

Verification
REQ-034 osc_in[0] period 8 clk (4 high/4 low), gate_len=64, start pulse -> busy for 66 cycles, done once, rd_sel=0 gives count 8 (+/-1 by phase), rd_ovf=0.
REQ-035 CNT_W=4 build, osc_in[1] period 2 clk, gate_len=100 -> rd_count=15, rd_ovf=1; channel 0 idle -> 0, ovf 0.
REQ-036 ch_en=4'b1011 with all osc toggling period 4, gate_len=40 -> ch2 reads 0, others 10 (+/-1); rd_sel=NUM_CH reads 0.
REQ-037 cont=1, gate_len=16, never ack -> done every 18 cycles, overrun=1 after second LATCH; res_ack then clears res_valid, overrun next cycle; ack coincident with LATCH keeps res_valid=1.
REQ-038 rst asserted at GATE cycle 10 of 32 -> next cycle IDLE, busy=0, res_valid=0, all counts 0, no done; gate_len=0 then start -> exactly 1 GATE cycle, done 3 cycles after start.
